// File: rtl/rotary_menu_if.sv
// rotary_menu_if: encoder/button inputs and menu outputs of rotary_menu_ctrl
//   rot_event_i  detent pulse from the rotary decoder
//   rot_dir_i    1=clockwise, 0=counter-clockwise, valid with rot_event_i
//   btn_n_i      raw active-low push button (asynchronous, bouncy)
//   sel_o        index of the selected register
//   val_o        value of the selected register
//   vals_o       all registers, reg k at [k*WIDTH +: WIDTH]
//   edit_o       1 while in EDIT mode
//   upd_o        1-cycle pulse when a register value changed
interface rotary_menu_if #(
    parameter int NUM_REGS = 4,
    parameter int WIDTH    = 8
);
    localparam int SW = $clog2(NUM_REGS);
    logic                      rot_event_i;
    logic                      rot_dir_i;
    logic                      btn_n_i;
    logic [SW-1:0]             sel_o;
    logic [WIDTH-1:0]          val_o;
    logic [NUM_REGS*WIDTH-1:0] vals_o;
    logic                      edit_o;
    logic                      upd_o;
    modport master (
        output rot_event_i, rot_dir_i, btn_n_i,
        input  sel_o, val_o, vals_o, edit_o, upd_o
    );
    modport slave (
        input  rot_event_i, rot_dir_i, btn_n_i,
        output sel_o, val_o, vals_o, edit_o, upd_o
    );
endinterface

// File: rtl/rotary_menu_ctrl.sv
// rotary_menu_ctrl: one rotary encoder + push button shared across NUM_REGS value registers
//   CLK_i  system clock
//   RST_i  synchronous reset, active-high
//   bus    rotary_menu_if.slave: rotation/button inputs, selection/value/mode/update outputs
//   BROWSE: rotation moves the selection (wrapping); EDIT: rotation steps the selected
//   register (saturating). Short press toggles the mode, long press clears the register.
module rotary_menu_ctrl #(
    parameter int NUM_REGS          = 4,
    parameter int WIDTH             = 8,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 64
) (
    input logic          CLK_i,
    input logic          RST_i,
    rotary_menu_if.slave bus
);
    localparam int SW = $clog2(NUM_REGS);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [0:0] BROWSE = 1'b0;
    localparam logic [0:0] EDIT   = 1'b1;
    logic             s1, s2, db, long_done;
    logic [DW-1:0]    dcnt;
    logic [HW-1:0]    hold_cnt;
    logic             pressed, accept, short_ev, long_ev;
    logic [0:0]       state, state_n;
    logic [SW-1:0]    sel, sel_n;
    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] regs_n [NUM_REGS];
    logic [WIDTH-1:0] cur, step, val_q;
    logic             upd, upd_n;
    assign pressed  = ~s2;
    // accept marks the cycle that completes DEBOUNCE_CYCLES consecutive mismatches
    assign accept   = (pressed != db) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign long_ev  = db && !long_done && (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));
    // a release after a long press was already consumed and produces nothing
    assign short_ev = accept && !pressed && !long_done && !long_ev;
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            db        <= 1'b0;
            dcnt      <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else begin
            s1 <= bus.btn_n_i;
            s2 <= s1;
            dcnt <= (pressed == db || accept) ? '0 : dcnt + 1'b1;
            if (accept)
                db <= pressed;
            if (accept && pressed) begin
                hold_cnt  <= '0;
                long_done <= 1'b0;
            end else if (db && !long_done) begin
                hold_cnt  <= hold_cnt + 1'b1;
                long_done <= long_ev;
            end
        end
    end
    always_comb begin
        regs_n  = regs;
        sel_n   = sel;
        upd_n   = 1'b0;
        cur     = regs[sel];
        step    = bus.rot_dir_i ? ((cur == '1) ? cur : cur + 1'b1)
                                : ((cur == '0) ? cur : cur - 1'b1);
        // clear beats a same-cycle edit step; rotation uses the pre-toggle mode
        if (long_ev) begin
            regs_n[sel] = '0;
            upd_n       = cur != '0;
        end else if (bus.rot_event_i && state == EDIT) begin
            regs_n[sel] = step;
            upd_n       = step != cur;
        end
        if (bus.rot_event_i && state == BROWSE)
            sel_n = bus.rot_dir_i ? ((sel == SW'(NUM_REGS - 1)) ? '0 : sel + 1'b1)
                                  : ((sel == '0) ? SW'(NUM_REGS - 1) : sel - 1'b1);
        state_n = short_ev ? ~state : state;
    end
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            sel   <= '0;
            state <= BROWSE;
            upd   <= 1'b0;
            val_q <= '0;
        end else begin
            regs  <= regs_n;
            sel   <= sel_n;
            state <= state_n;
            upd   <= upd_n;
            val_q <= regs_n[sel_n];
        end
    end
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_vals
        assign bus.vals_o[k*WIDTH +: WIDTH] = regs[k];
    end
    assign bus.sel_o  = sel;
    assign bus.val_o  = val_q;
    assign bus.edit_o = state == EDIT;
    assign bus.upd_o  = upd;
endmodule
